// File: rtl/tor_slot_sync_pkg.sv
// tor_slot_pkg: shared constants, field offsets and state encodings for the ToR slot-announce receiver.
package tor_slot_pkg;
   localparam logic [15:0] ANNOUNCE_TYPE = 16'h0F01;
   localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
   localparam int          TYPE_LSB      = 0;
   localparam int          MAC_LSB       = 16;
   localparam int          ID_LSB        = 0;
   localparam int          ID_KEEP_BIT   = 0;

   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
   typedef enum logic [1:0] {WAIT_HDR, HDR_OK, SKIP} parser_state_e;

   function automatic logic hdr_match(input logic [63:0] beat0, input logic [47:0] my_mac);
      logic [47:0] dest;
      dest = beat0[MAC_LSB +: 48];
      return beat0[TYPE_LSB +: 16] == ANNOUNCE_TYPE && (dest == BCAST_MAC || dest == my_mac);
   endfunction
endpackage

// File: rtl/tor_slot_sync_if.sv
// tor_slot_sync_if: control-channel RX stream bundle between the MAC and the slot-sync receiver.
interface tor_slot_sync_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tready;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/tor_slot_sync_frame_parser.sv
// tor_slot_frame_parser: parses announce frames and emits a registered sync pulse with the announced slot id.
// With SLOT_SYNC_STAT_EN a registered drop pulse is also produced for every discarded frame.
module tor_slot_frame_parser
   import tor_slot_pkg::*;
#(
   parameter logic [47:0] P_MY_TOR_MAC = 48'h8D_BC_5C_4A_00_00,
   parameter int unsigned P_SLOT_NUM   = 2,
   parameter int          P_SLOT_ID_W  = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   tor_slot_sync_if.slave         rx_axis,
   output logic                   o_sync,
   output logic [P_SLOT_ID_W-1:0] o_slot_id
`ifdef SLOT_SYNC_STAT_EN
   ,
   output logic                   o_drop
`endif
);
   parser_state_e          state_q, state_d;
   logic                   sync_q, sync_d, drop_q, drop_d, fire, id_ok;
   logic [P_SLOT_ID_W-1:0] id_q, id_d;

   assign rx_axis.tready = ~i_rst;
   assign fire  = rx_axis.tvalid & rx_axis.tready;
   assign id_ok = rx_axis.tkeep[ID_KEEP_BIT] && 32'(rx_axis.tdata[ID_LSB +: P_SLOT_ID_W]) < P_SLOT_NUM;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= WAIT_HDR;
         sync_q  <= 1'b0;
         drop_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         drop_q  <= drop_d;
         id_q    <= id_d;
      end
   end

   // Drop is flagged once per frame, at the beat where the frame is first known to be bad.
   always_comb begin
      state_d = state_q;
      sync_d  = 1'b0;
      drop_d  = 1'b0;
      id_d    = id_q;
      if (fire) begin
         case (state_q)
            WAIT_HDR: begin
               state_d = rx_axis.tlast ? WAIT_HDR : hdr_match(rx_axis.tdata, P_MY_TOR_MAC) ? HDR_OK : SKIP;
               drop_d  = rx_axis.tlast | ~hdr_match(rx_axis.tdata, P_MY_TOR_MAC);
            end
            HDR_OK: begin
               state_d = rx_axis.tlast ? WAIT_HDR : SKIP;
               sync_d  = id_ok;
               drop_d  = ~id_ok;
               id_d    = id_ok ? rx_axis.tdata[ID_LSB +: P_SLOT_ID_W] : id_q;
            end
            default: state_d = rx_axis.tlast ? WAIT_HDR : SKIP;
         endcase
      end
   end

   assign o_sync    = sync_q;
   assign o_slot_id = id_q;
`ifdef SLOT_SYNC_STAT_EN
   assign o_drop    = drop_q;
`endif
endmodule

// File: rtl/tor_slot_sync.sv
// tor_slot_sync: aligns a free-running slot counter to controller announces and drives slot timing outputs.
// Optional macro SLOT_SYNC_STAT_EN adds sync/drop counters and the last observed phase error.
module tor_slot_sync
   import tor_slot_pkg::*;
#(
   parameter logic [47:0] P_MY_TOR_MAC   = 48'h8D_BC_5C_4A_00_00,
   parameter logic [31:0] P_SLOT_LEN     = 32'h0000_5CD0,
   parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_0960,
   parameter int unsigned P_SLOT_NUM     = 2,
   parameter int          P_SLOT_ID_W    = 1,
   parameter int unsigned P_LOSS_SLOTS   = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   tor_slot_sync_if.slave         rx_axis,
   output logic                   o_locked,
   output logic [P_SLOT_ID_W-1:0] o_slot_id,
   output logic                   o_slot_start,
   output logic                   o_cfg_window,
   output logic                   o_tx_allow
`ifdef SLOT_SYNC_STAT_EN
   ,
   output logic [31:0]            o_stat_sync_cnt,
   output logic [31:0]            o_stat_drop_cnt,
   output logic [31:0]            o_stat_phase_err
`endif
);
   localparam logic [P_SLOT_ID_W-1:0] LAST_ID = P_SLOT_ID_W'(P_SLOT_NUM - 1);

   lock_state_e            lock_q, lock_d;
   logic [31:0]            cnt_q, cnt_d, miss_q, miss_d;
   logic [P_SLOT_ID_W-1:0] slot_q, slot_d, sync_id;
   logic                   start_q, start_d, cfg_q, cfg_d, allow_q, allow_d, sync;

`ifdef SLOT_SYNC_STAT_EN
   logic        drop;
   logic [31:0] sync_cnt_q, drop_cnt_q, phase_q;
`endif

   tor_slot_frame_parser #(
      .P_MY_TOR_MAC (P_MY_TOR_MAC),
      .P_SLOT_NUM   (P_SLOT_NUM),
      .P_SLOT_ID_W  (P_SLOT_ID_W)
   ) u_parser (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .rx_axis   (rx_axis),
      .o_sync    (sync),
      .o_slot_id (sync_id)
`ifdef SLOT_SYNC_STAT_EN
      ,
      .o_drop    (drop)
`endif
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lock_q  <= UNLOCKED;
         cnt_q   <= '0;
         miss_q  <= '0;
         slot_q  <= '0;
         start_q <= 1'b0;
         cfg_q   <= 1'b0;
         allow_q <= 1'b0;
      end else begin
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         miss_q  <= miss_d;
         slot_q  <= slot_d;
         start_q <= start_d;
         cfg_q   <= cfg_d;
         allow_q <= allow_d;
      end
   end

   // A sync always wins over a wrap in the same cycle; losing lock puts every output back to idle.
   always_comb begin
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      slot_d  = slot_q;
      start_d = 1'b0;
      if (sync) begin
         lock_d  = LOCKED;
         cnt_d   = '0;
         miss_d  = '0;
         slot_d  = sync_id;
         start_d = 1'b1;
      end else if (lock_q == LOCKED) begin
         if (cnt_q == P_SLOT_LEN - 32'd1) begin
            cnt_d   = '0;
            slot_d  = slot_q == LAST_ID ? '0 : slot_q + 1'b1;
            start_d = 1'b1;
            miss_d  = miss_q == '1 ? miss_q : miss_q + 32'd1;
            if (miss_d >= P_LOSS_SLOTS) begin
               lock_d  = UNLOCKED;
               slot_d  = '0;
               start_d = 1'b0;
               miss_d  = '0;
            end
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
      cfg_d   = lock_d == LOCKED && cnt_d < P_CONFIG_DELAY;
      allow_d = lock_d == LOCKED && !cfg_d;
   end

   assign o_locked     = lock_q == LOCKED;
   assign o_slot_id    = slot_q;
   assign o_slot_start = start_q;
   assign o_cfg_window = cfg_q;
   assign o_tx_allow   = allow_q;

`ifdef SLOT_SYNC_STAT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_cnt_q <= '0;
         drop_cnt_q <= '0;
         phase_q    <= '0;
      end else begin
         sync_cnt_q <= sync_cnt_q + {31'd0, sync};
         drop_cnt_q <= drop_cnt_q + {31'd0, drop};
         phase_q    <= sync && lock_q == LOCKED ? cnt_q : phase_q;
      end
   end

   assign o_stat_sync_cnt  = sync_cnt_q;
   assign o_stat_drop_cnt  = drop_cnt_q;
   assign o_stat_phase_err = phase_q;
`endif
endmodule

// File: tb/tb_tor_slot_sync.sv
// tb_tor_slot_sync: directed and randomized announce traffic against a time-since-sync reference model.
module tb_tor_slot_sync;
   localparam int          LEN  = 100;
   localparam int          CFG  = 20;
   localparam int          LOSS = 4;
   localparam int          NUM  = 2;
   localparam logic [47:0] MY   = 48'h8D_BC_5C_4A_00_00;
   localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] BAD  = 48'h8D_BC_5C_4A_05_00;
   localparam logic [15:0] TYP  = 16'h0F01;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tor_slot_sync_if rx();
   logic locked, slot_id, slot_start, cfg_window, tx_allow;
`ifdef SLOT_SYNC_STAT_EN
   logic [31:0] st_sync, st_drop, st_phase;
`endif

   tor_slot_sync #(
      .P_MY_TOR_MAC   (MY),
      .P_SLOT_LEN     (32'd100),
      .P_CONFIG_DELAY (32'd20),
      .P_SLOT_NUM     (2),
      .P_SLOT_ID_W    (1),
      .P_LOSS_SLOTS   (4)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .rx_axis      (rx),
      .o_locked     (locked),
      .o_slot_id    (slot_id),
      .o_slot_start (slot_start),
      .o_cfg_window (cfg_window),
      .o_tx_allow   (tx_allow)
`ifdef SLOT_SYNC_STAT_EN
      ,
      .o_stat_sync_cnt  (st_sync),
      .o_stat_drop_cnt  (st_drop),
      .o_stat_phase_err (st_phase)
`endif
   );

   int checks = 0, failures = 0, edge_n = 0;
   // Model: lock state is a function of edges elapsed since the last applied sync.
   bit mlock = 0, pend_s = 0, pend_d = 0;
   int t_sync = 0, sid = 0, pend_s_edge = 0, pend_d_edge = 0, pend_id = 0;
   int unsigned m_sync = 0, m_drop = 0, m_phase = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic check_outputs();
      int ph, cnt;
      bit lk;
      ph  = edge_n - t_sync;
      lk  = mlock && ph < LOSS * LEN;
      cnt = lk ? ph % LEN : 0;
      check("tready", {31'd0, rx.tready}, {31'd0, !rst});
      check("locked", {31'd0, locked}, {31'd0, lk});
      check("slot_id", {31'd0, slot_id}, lk ? (sid + ph / LEN) % NUM : 0);
      check("slot_start", {31'd0, slot_start}, {31'd0, lk && cnt == 0});
      check("cfg_window", {31'd0, cfg_window}, {31'd0, lk && cnt < CFG});
      check("tx_allow", {31'd0, tx_allow}, {31'd0, lk && cnt >= CFG});
`ifdef SLOT_SYNC_STAT_EN
      check("stat_sync", st_sync, m_sync);
      check("stat_drop", st_drop, m_drop);
      check("stat_phase", st_phase, m_phase);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      edge_n++;
      #1;
      if (pend_d && edge_n == pend_d_edge) begin
         m_drop++;
         pend_d = 0;
      end
      if (pend_s && edge_n == pend_s_edge) begin
         if (mlock && edge_n - 1 - t_sync < LOSS * LEN) m_phase = (edge_n - 1 - t_sync) % LEN;
         mlock  = 1;
         t_sync = edge_n;
         sid    = pend_id;
         m_sync++;
         pend_s = 0;
      end
      if (mlock && edge_n - t_sync >= LOSS * LEN) mlock = 0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      rx.tvalid = 1'b0;
      rx.tlast  = 1'b0;
      repeat (n) step();
   endtask

   task automatic idle_to(input int target);
      rx.tvalid = 1'b0;
      rx.tlast  = 1'b0;
      while (edge_n < target) step();
   endtask

   task automatic send_frame(input logic [47:0] mac, input logic [15:0] typ, input bit id,
                             input bit keep0, input int nbeats, input bit bubbles);
      bit hdr;
      logic [63:0] r;
      hdr = typ == TYP && (mac == BC || mac == MY);
      for (int b = 0; b < nbeats; b++) begin
         if (bubbles) repeat ($urandom_range(0, 2)) begin
            rx.tvalid = 1'b0;
            rx.tdata  = {$urandom, $urandom};
            step();
         end
         r = {$urandom, $urandom};
         if (b == 0) r = {mac, typ};
         if (b == 1) r[0] = id;
         rx.tdata  = r;
         rx.tkeep  = 8'($urandom);
         if (b == 1) rx.tkeep[0] = keep0;
         rx.tvalid = 1'b1;
         rx.tlast  = b == nbeats - 1;
         step();
         if (b == 0 && (nbeats == 1 || !hdr)) begin
            pend_d = 1;
            pend_d_edge = edge_n + 1;
         end
         if (b == 1 && hdr && keep0) begin
            pend_s = 1;
            pend_s_edge = edge_n + 1;
            pend_id = id;
         end
         if (b == 1 && hdr && !keep0) begin
            pend_d = 1;
            pend_d_edge = edge_n + 1;
         end
      end
      rx.tvalid = 1'b0;
      rx.tlast  = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      #2 rst = 1'b1;
      rx.tvalid = 1'b0;
      rx.tlast  = 1'b0;
      mlock = 0; pend_s = 0; pend_d = 0;
      m_sync = 0; m_drop = 0; m_phase = 0;
      #1 check_outputs();
      repeat (cycles) step();
      rst = 1'b0;
   endtask

   initial begin
      int kind;
      rx.tvalid = 1'b0;
      rx.tlast  = 1'b0;
      rx.tdata  = '0;
      rx.tkeep  = '0;
      #1 check_outputs();
      repeat (3) step();
      rst = 1'b0;
      idle(2);
      // Broadcast lock, full slot timing and id rollover
      send_frame(BC, TYP, 1'b1, 1'b1, 2, 1'b0);
      idle(210);
      // Bad type, bad MAC, tlast on beat0 are ignored; a good frame still locks
      do_reset(2);
      send_frame(BC, 16'h0800, 1'b1, 1'b1, 2, 1'b0);
      send_frame(BAD, TYP, 1'b1, 1'b1, 3, 1'b0);
      send_frame(MY, TYP, 1'b1, 1'b1, 1, 1'b0);
      send_frame(MY, TYP, 1'b1, 1'b0, 2, 1'b0);
      idle(5);
      send_frame(MY, TYP, 1'b1, 1'b1, 2, 1'b0);
      idle(30);
      // Mid-slot realignment at counter 57
      idle_to(t_sync + LEN + 55);
      send_frame(MY, TYP, 1'b0, 1'b1, 3, 1'b0);
      idle(40);
      // Sync coinciding with the wrap cycle
      idle_to(t_sync + 97);
      send_frame(BC, TYP, 1'b1, 1'b1, 2, 1'b0);
      idle(20);
      // Loss of lock after four missed wraps
      idle(420);
      // Reset after lock and mid-frame, then a 3-beat frame locks again
      send_frame(BC, TYP, 1'b0, 1'b1, 2, 1'b0);
      idle(10);
      rx.tvalid = 1'b1;
      rx.tdata  = {BC, TYP};
      rx.tlast  = 1'b0;
      step();
      do_reset(3);
      send_frame(BC, TYP, 1'b1, 1'b1, 3, 1'b0);
      idle(120);
      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            5: send_frame(BC, 16'($urandom) | 16'h1000, 1'($urandom), 1'b1, $urandom_range(2, 4), 1'b1);
            6: send_frame(BAD, TYP, 1'($urandom), 1'b1, $urandom_range(2, 4), 1'b1);
            7: send_frame(BC, TYP, 1'($urandom), 1'b1, 1, 1'b1);
            8: send_frame(MY, TYP, 1'($urandom), 1'b0, $urandom_range(2, 4), 1'b1);
            default: send_frame(kind[0] ? BC : MY, TYP, 1'($urandom), 1'b1, $urandom_range(2, 4), 1'b1);
         endcase
         idle($urandom_range(0, 3) == 0 ? $urandom_range(300, 450) : $urandom_range(0, 60));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
